quad_position_counter: RTL



---
 rtl/quad_position_counter_if.sv | 28 ++
 rtl/quad_position_counter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/quad_position_counter_if.sv
// Connection bundle for the quadrature position counter: decoder pulses and
// control in, position/status and serial readout out.
interface quad_position_counter_if #(
    parameter int WIDTH = 8
);
    logic             step_up;
    logic             step_dn;
    logic             step_err;
    logic             clr;
    logic             snap;
    logic [WIDTH-1:0] pos;
    logic             dir;
    logic             err_sticky;
    logic             ovf_sticky;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;

    modport master (
        output step_up, step_dn, step_err, clr, snap,
        input  pos, dir, err_sticky, ovf_sticky, ser_out, ser_valid, busy
    );

    modport slave (
        input  step_up, step_dn, step_err, clr, snap,
        output pos, dir, err_sticky, ovf_sticky, ser_out, ser_valid, busy
    );
endinterface

// File: rtl/quad_position_counter.sv
// Position counter behind the quadrature step decoder, with sticky error and
// overflow flags and an MSB-first serial snapshot readout.
module quad_position_counter #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input logic                    clk,
    input logic                    rst_n,
    quad_position_counter_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] POS_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_e;

    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;

    logic up_only;
    logic dn_only;
    logic load;

    assign up_only = bus.step_up & ~bus.step_dn;
    assign dn_only = bus.step_dn & ~bus.step_up;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        err_d = err_q | bus.step_err | (bus.step_up & bus.step_dn);
        ovf_d = ovf_q;

        if (up_only) begin
            dir_d = 1'b1;
            if (pos_q == POS_MAX) begin
                ovf_d = 1'b1;
                pos_d = (SATURATE != 0) ? POS_MAX : POS_MIN;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end else if (dn_only) begin
            dir_d = 1'b0;
            if (pos_q == POS_MIN) begin
                ovf_d = 1'b1;
                pos_d = (SATURATE != 0) ? POS_MIN : POS_MAX;
            end else begin
                pos_d = pos_q - 1'b1;
            end
        end

        // Clear wins over everything in the same cycle, including the step's dir.
        if (bus.clr) begin
            pos_d = '0;
            dir_d = dir_q;
            err_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    // A new frame may start from IDLE or on the last bit of the current frame,
    // which makes back-to-back frames gapless.
    assign load = bus.snap && ((state_q == IDLE) || (bit_cnt_q == LAST_BIT));

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        ser_valid_d = ser_valid_q;
        busy_d      = busy_q;

        if (load) begin
            state_d     = SHIFT;
            shreg_d     = pos_d;
            bit_cnt_d   = '0;
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
        end else if (state_q == SHIFT) begin
            if (bit_cnt_q == LAST_BIT) begin
                state_d     = IDLE;
                shreg_d     = '0;
                bit_cnt_d   = '0;
                ser_valid_d = 1'b0;
                busy_d      = 1'b0;
            end else begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q       <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
        end
    end

    // shreg is zero outside a frame, so its MSB doubles as the idle-low ser_out.
    assign bus.pos        = pos_q;
    assign bus.dir        = dir_q;
    assign bus.err_sticky = err_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.ser_out    = shreg_q[WIDTH-1];
    assign bus.ser_valid  = ser_valid_q;
    assign bus.busy       = busy_q;
endmodule
